axi2ahb_lite_bridge: RTL

AXI2AHB_LITE_BRIDGE -- requirements
Module: axi2ahb_lite_bridge

---
 rtl/axi2ahb_lite_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/axi2ahb_lite_bridge.sv
// AXI4-Lite slave to AHB-Lite master bridge: one outstanding single-beat transfer,
// write/read arbitration alternates when both are pending.
module axi2ahb_lite_bridge #(
    parameter logic [3:0] HPROT_VAL       = 4'b0011,
    parameter bit         ERR_ON_BAD_STRB = 1'b1
) (
    input  logic        core_clk_i,
    input  logic        core_rstn_i,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] m_ahb_haddr,
    output logic [1:0]  m_ahb_htrans,
    output logic        m_ahb_hwrite,
    output logic [2:0]  m_ahb_hsize,
    output logic [2:0]  m_ahb_hburst,
    output logic [3:0]  m_ahb_hprot,
    output logic [31:0] m_ahb_hwdata,
    input  logic [31:0] m_ahb_hrdata,
    input  logic        m_ahb_hready,
    input  logic        m_ahb_hresp,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Handshake rule: every channel transfers on a cycle where valid && ready;
    // readies are only offered in IDLE, so at most one transaction is in flight.

    logic [1:0]  state;
    logic        is_write;
    logic        wr_next;
    logic        err_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [31:0] hwdata_q;
    logic [31:0] rdata_q;

    logic        idle_ok;
    logic        wr_pend;
    logic        grant_wr;
    logic        grant_rd;
    logic        strb_ok;
    logic        bad_strb;
    logic [2:0]  strb_size;
    logic [1:0]  strb_lsb;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Readies are masked during reset so nothing is offered while the FSM is held.
    assign idle_ok  = (state == ST_IDLE) && core_rstn_i;
    assign wr_pend  = s_axi_awvalid && s_axi_wvalid;
    assign grant_wr = idle_ok && wr_pend && (!s_axi_arvalid || wr_next);
    assign grant_rd = idle_ok && s_axi_arvalid && !grant_wr;

    always_comb begin
        strb_ok   = 1'b1;
        strb_size = 3'b010;
        strb_lsb  = 2'b00;
        case (s_axi_wstrb)
            4'b1111: ;
            4'b0011: strb_size = 3'b001;
            4'b1100: begin strb_size = 3'b001; strb_lsb = 2'b10; end
            4'b0001: begin strb_size = 3'b000; strb_lsb = 2'b00; end
            4'b0010: begin strb_size = 3'b000; strb_lsb = 2'b01; end
            4'b0100: begin strb_size = 3'b000; strb_lsb = 2'b10; end
            4'b1000: begin strb_size = 3'b000; strb_lsb = 2'b11; end
            default: strb_ok = 1'b0;
        endcase
    end

    // With the error check disabled, odd strobes fall back to a full-word write.
    assign bad_strb = !strb_ok && ERR_ON_BAD_STRB;

    always_ff @(posedge core_clk_i or negedge core_rstn_i) begin
        if (!core_rstn_i) begin
            state    <= ST_IDLE;
            is_write <= 1'b0;
            wr_next  <= 1'b1;
            err_q    <= 1'b0;
            haddr_q  <= 32'h0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b010;
            hwdata_q <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_wr) begin
                        is_write <= 1'b1;
                        wr_next  <= 1'b0;
                        haddr_q  <= {s_axi_awaddr[31:2], strb_lsb};
                        hsize_q  <= strb_size;
                        hwrite_q <= 1'b1;
                        hwdata_q <= s_axi_wdata;
                        err_q    <= bad_strb;
                        state    <= bad_strb ? ST_RESP : ST_ADDR;
                    end else if (grant_rd) begin
                        is_write <= 1'b0;
                        wr_next  <= 1'b1;
                        haddr_q  <= {s_axi_araddr[31:2], 2'b00};
                        hsize_q  <= 3'b010;
                        hwrite_q <= 1'b0;
                        err_q    <= 1'b0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_ahb_hready) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (m_ahb_hready) begin
                        if (!is_write) rdata_q <= m_ahb_hrdata;
                        err_q <= m_ahb_hresp;
                        state <= ST_RESP;
                    end
                end
                default: begin
                    if (is_write ? s_axi_bready : s_axi_rready) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axi_awready = grant_wr;
    assign s_axi_wready  = grant_wr;
    assign s_axi_arready = grant_rd;

    assign s_axi_bvalid  = (state == ST_RESP) && is_write;
    assign s_axi_rvalid  = (state == ST_RESP) && !is_write;
    assign s_axi_bresp   = {err_q, 1'b0};
    assign s_axi_rresp   = {err_q, 1'b0};
    assign s_axi_rdata   = rdata_q;

    assign m_ahb_htrans  = (state == ST_ADDR) ? 2'b10 : 2'b00;
    assign m_ahb_haddr   = haddr_q;
    assign m_ahb_hwrite  = hwrite_q;
    assign m_ahb_hsize   = hsize_q;
    assign m_ahb_hburst  = 3'b000;
    assign m_ahb_hprot   = HPROT_VAL;
    assign m_ahb_hwdata  = hwdata_q;

    assign dbg_state     = state;

endmodule
